// File: rtl/mmu_output_scheduler.sv
// rtl/mmu_output_scheduler.sv - double-buffered byte drain of 2x2 MMU results
//
// Captures c00 at mmu_cycle 2, c01/c10 at mmu_cycle 3, and commits the set
// {c00, c01, c10, live c11} at mmu_cycle 4. A committed set goes straight to
// the output bank when it is free, otherwise into the pending bank. The
// output bank is streamed as eight bytes in the order c00, c01, c10, c11.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mmu_en, mmu_cycle     MMU activity and phase (0..7)
//   c00, c01, c10, c11    MMU results
//   out_ready             host accepts out_data
//   clr_ovf               clears the sticky overflow flag
//   out_data, out_valid   byte stream (out_data is 0 while out_valid=0)
//   busy                  out_valid | pending
//   overflow              a pending set was overwritten
module mmu_output_scheduler #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmu_en,
    input  logic [2:0]  mmu_cycle,
    input  logic [15:0] c00,
    input  logic [15:0] c01,
    input  logic [15:0] c10,
    input  logic [15:0] c11,
    input  logic        out_ready,
    input  logic        clr_ovf,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        EMPTY       = 2'd0,
        STREAM      = 2'd1,
        STREAM_PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      s_c00_q, s_c00_d;
    logic [15:0]      s_c01_q, s_c01_d;
    logic [15:0]      s_c10_q, s_c10_d;
    logic [3:0][15:0] p_q, p_d;
    logic [3:0][15:0] o_q, o_d;
    logic             ovf_q, ovf_d;

    logic             pending;
    logic             commit;
    logic             accept;
    logic             last;
    logic             o_free;
    logic [3:0][15:0] set_w;
    logic [15:0]      cur_word;

    assign commit = mmu_en && (mmu_cycle == 3'd4);
    assign accept = out_valid && out_ready;
    assign last   = accept && (idx_q == 3'd7);
    assign o_free = !out_valid || last;
    assign set_w  = {c11, s_c10_q, s_c01_q, s_c00_q};

    // State register plus datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            idx_q   <= 3'd0;
            s_c00_q <= 16'd0;
            s_c01_q <= 16'd0;
            s_c10_q <= 16'd0;
            p_q     <= '0;
            o_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            s_c00_q <= s_c00_d;
            s_c01_q <= s_c01_d;
            s_c10_q <= s_c10_d;
            p_q     <= p_d;
            o_q     <= o_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (commit) state_d = STREAM;
            end
            STREAM: begin
                if (commit && !o_free)      state_d = STREAM_PEND;
                else if (last && !commit)   state_d = EMPTY;
            end
            STREAM_PEND: begin
                // A commit on the last byte takes O directly, so P stays held.
                if (last && !commit)        state_d = STREAM;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output decode (registers only; no path from out_ready)
    always_comb begin
        out_valid = (state_q != EMPTY);
        pending   = (state_q == STREAM_PEND);
        busy      = out_valid || pending;
        overflow  = ovf_q;
        cur_word  = o_q[idx_q[2:1]];
        out_data  = 8'd0;
        if (out_valid) begin
            out_data = (idx_q[0] ^ LSB_FIRST) ? cur_word[7:0] : cur_word[15:8];
        end
    end

    // Capture, bank transfers and byte index
    always_comb begin
        s_c00_d = s_c00_q;
        s_c01_d = s_c01_q;
        s_c10_d = s_c10_q;
        p_d     = p_q;
        o_d     = o_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;

        if (mmu_en && (mmu_cycle == 3'd2)) s_c00_d = c00;
        if (mmu_en && (mmu_cycle == 3'd3)) begin
            s_c01_d = c01;
            s_c10_d = c10;
        end

        if (accept) idx_d = idx_q + 3'd1;

        if (commit) begin
            if (o_free) begin
                o_d   = set_w;
                idx_d = 3'd0;
            end else begin
                p_d = set_w;
                if (pending) ovf_d = 1'b1;
            end
        end else if (last && pending) begin
            o_d   = p_q;
            idx_d = 3'd0;
        end

        // Setting wins over clearing at the same edge.
        if (!(commit && !o_free && pending) && clr_ovf) ovf_d = 1'b0;
    end

endmodule

// File: tb/tb_mmu_output_scheduler.sv
// tb/tb_mmu_output_scheduler.sv - randomized bench with queue-based reference model
module tb_mmu_output_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmu_en;
    logic [2:0]  mmu_cycle;
    logic [15:0] c00, c01, c10, c11;
    logic        out_ready;
    logic        clr_ovf;
    logic [7:0]  out_data0, out_data1;
    logic        out_valid0, out_valid1;
    logic        busy0, busy1;
    logic        overflow0, overflow1;

    always #5 clk = ~clk;

    mmu_output_scheduler #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .mmu_en(mmu_en), .mmu_cycle(mmu_cycle),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .out_ready(out_ready), .clr_ovf(clr_ovf),
        .out_data(out_data0), .out_valid(out_valid0),
        .busy(busy0), .overflow(overflow0)
    );

    mmu_output_scheduler #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .mmu_en(mmu_en), .mmu_cycle(mmu_cycle),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .out_ready(out_ready), .clr_ovf(clr_ovf),
        .out_data(out_data1), .out_valid(out_valid1),
        .busy(busy1), .overflow(overflow1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each entry is {high-first byte, low-first byte}.
    logic [15:0] m_out_q[$];
    logic [15:0] m_pend_q[$];
    logic [15:0] m_s00, m_s01, m_s10;
    logic        m_ovf;
    logic [2:0]  cyc;

    logic        recording = 1'b0;
    logic [7:0]  rec0[$];
    logic [7:0]  rec1[$];
    int          valid_count = 0;

    task automatic model_reset();
        m_out_q.delete();
        m_pend_q.delete();
        m_s00 = 16'd0;
        m_s01 = 16'd0;
        m_s10 = 16'd0;
        m_ovf = 1'b0;
    endtask

    task automatic step(input bit en, input bit rdy, input bit clr, input bit r,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        logic [15:0] set_bytes[$];
        logic [15:0] words[4];
        bit          had_out, acc, lst, free, ovf_set;

        // Compare DUT outputs to the model state left by the previous edge.
        check("out_valid", out_valid0, m_out_q.size() != 0);
        check("out_valid_lsb", out_valid1, m_out_q.size() != 0);
        check("out_data", out_data0, (m_out_q.size() != 0) ? m_out_q[0][15:8] : 8'd0);
        check("out_data_lsb", out_data1, (m_out_q.size() != 0) ? m_out_q[0][7:0] : 8'd0);
        check("busy", busy0, (m_out_q.size() != 0) || (m_pend_q.size() != 0));
        check("overflow", overflow0, m_ovf);
        check("overflow_lsb", overflow1, m_ovf);
        if (out_valid0) valid_count++;
        if (recording && out_valid0) begin
            rec0.push_back(out_data0);
            rec1.push_back(out_data1);
        end

        rst = r; mmu_en = en; mmu_cycle = cyc; out_ready = rdy; clr_ovf = clr;
        c00 = a; c01 = b; c10 = c; c11 = d;

        if (r) begin
            model_reset();
        end else begin
            had_out = (m_out_q.size() != 0);
            acc     = had_out && rdy;
            lst     = acc && (m_out_q.size() == 1);
            free    = !had_out || lst;
            ovf_set = 1'b0;
            if (acc) void'(m_out_q.pop_front());
            words[0] = m_s00; words[1] = m_s01; words[2] = m_s10; words[3] = d;
            for (int k = 0; k < 4; k++) begin
                set_bytes.push_back({words[k][15:8], words[k][7:0]});
                set_bytes.push_back({words[k][7:0], words[k][15:8]});
            end
            if (en && cyc == 3'd4) begin
                if (free) begin
                    m_out_q = set_bytes;
                end else begin
                    if (m_pend_q.size() != 0) ovf_set = 1'b1;
                    m_pend_q = set_bytes;
                end
            end else if (lst && m_pend_q.size() != 0) begin
                m_out_q = m_pend_q;
                m_pend_q.delete();
            end
            if (en && cyc == 3'd2) m_s00 = a;
            if (en && cyc == 3'd3) begin
                m_s01 = b;
                m_s10 = c;
            end
            if (ovf_set) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
        cyc = cyc + 3'd1;
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    initial begin
        logic [7:0] exp_bytes[8];
        exp_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFE};

        rst = 1'b1; mmu_en = 1'b0; mmu_cycle = 3'd0; out_ready = 1'b0; clr_ovf = 1'b0;
        c00 = 16'd0; c01 = 16'd0; c10 = 16'd0; c11 = 16'd0;
        model_reset();
        cyc = 3'd0;
        @(posedge clk);
        @(negedge clk);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        cyc = 3'd0;

        // Single matmul with known values
        recording = 1'b1;
        for (int i = 0; i < 8; i++)
            step(1, 1, 0, 0, (cyc == 3'd2) ? 16'h1234 : rnd16(),
                 (cyc == 3'd3) ? 16'hABCD : rnd16(), (cyc == 3'd3) ? 16'h0001 : rnd16(),
                 (cyc == 3'd4) ? 16'hFFFE : rnd16());
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
        recording = 1'b0;
        check("single_count", rec0.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < rec0.size()) check("single_byte", rec0[i], exp_bytes[i]);
        if (rec1.size() >= 2) begin
            check("lsb_first_b0", rec1[0], 8'h34);
            check("lsb_first_b1", rec1[1], 8'h12);
        end
        check("single_idle", out_valid0, 0);

        // Back-to-back sets over three MMU periods
        cyc = 3'd0;
        valid_count = 0;
        for (int i = 0; i < 24; i++) step(1, 1, 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
        check("b2b_bytes", valid_count, 24);
        check("b2b_ovf", overflow0, 0);

        // Stall while the second set commits
        cyc = 3'd0;
        for (int i = 0; i < 16; i++) begin
            step(1, (i == 5), 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
            if (i == 14) check("stall_busy", busy0, 1);
        end
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
        check("stall_ovf", overflow0, 0);

        // Two further commits while stalled: overflow, sticky, then cleared
        cyc = 3'd0;
        for (int i = 0; i < 26; i++)
            step(i < 24, (i == 5), 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
        check("ovf_set", overflow0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
        check("ovf_sticky", overflow0, 1);
        step(0, 1, 1, 0, rnd16(), rnd16(), rnd16(), rnd16());
        check("ovf_clr", overflow0, 0);

        // mmu_en dropped at cycle 3: no commit
        cyc = 3'd0;
        for (int i = 0; i < 16; i++)
            step(cyc < 3'd3 && i < 8, 1, 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
        check("partial_idle", out_valid0, 0);

        // Reset mid-stream at idx 3 with a pending set
        cyc = 3'd0;
        for (int i = 0; i < 14; i++)
            step(1, (i >= 5 && i <= 7), 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
        check("pre_rst_busy", busy0, 1);
        step(1, 0, 0, 1, rnd16(), rnd16(), rnd16(), rnd16());
        check("rst_valid", out_valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_data", out_data0, 0);
        cyc = 3'd0;

        // Random traffic
        for (int i = 0; i < 2000; i++)
            step(($urandom % 10) != 0, ($urandom % 10) < 7, ($urandom % 20) == 0,
                 ($urandom % 150) == 0, rnd16(), rnd16(), rnd16(), rnd16());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmu_output_scheduler.md
# mmu_output_scheduler

Schedules result drain for the 2x2 systolic MMU. It captures the four 16-bit results (c00, c01, c10, c11) at the MMU cycles where each becomes valid, and double-buffers them. It then streams them as eight bytes over an 8-bit valid/ready output port. The block sits between the MMU/control unit and the chip output pins, so the host can stall output without corrupting the next matmul.

## Interface
- LSB_FIRST, 0, byte order within each 16-bit result: 0 = high byte first, 1 = low byte first
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mmu_en  in  1  MMU active; captures only occur while high
- mmu_cycle  in  3  MMU phase counter, 0..7, wraps
- c00, c01, c10, c11  in  16 each  MMU result outputs, two's complement
- out_ready  in  1  host accepts out_data this cycle
- clr_ovf  in  1  clears the overflow flag
- out_data  out  8  current byte; forced to 0 when out_valid=0
- out_valid  out  1  out_data holds a valid byte
- busy  out  1  out_valid | pending
- overflow  out  1  sticky; a pending result set was overwritten

## Operation
- Storage: staging bank S (c00, c01, c10 regs), pending bank P (4x16) with pending flag, output bank O (4x16), byte index idx[2:0].
- Capture, at an edge with mmu_en=1:
  - mmu_cycle==2: S.c00 <= c00.
  - mmu_cycle==3: S.c01 <= c01, S.c10 <= c10.
  - mmu_cycle==4: commit. The set is {S.c00, S.c01, S.c10, live c11}.
- The output is free at an edge when out_valid=0, or when out_valid & out_ready & idx==7.
- Commit when O is free: O <= set, idx <= 0, out_valid <= 1. Pending is untouched.
- Commit when O is not free:
  - P <= set, pending <= 1.
  - If pending was already 1, set overflow <= 1. The older P is lost.
- Advance: on out_valid & out_ready, idx <= idx+1.
- When idx==7 is accepted:
  - If a commit occurs at the same edge, the commit takes O. Pending stays as is.
  - Else if pending=1: O <= P, pending <= 0, idx <= 0, out_valid stays 1 (zero bubble).
  - Else out_valid <= 0.
- Byte stream order: c00, c01, c10, c11.
  - idx even → first byte of the word (high byte if LSB_FIRST=0, else low byte).
  - idx odd → the other byte.
- A partial set (mmu_en dropping before cycle 4) is never committed. Stale S contents are overwritten by later captures.
- overflow: set as above; cleared by clr_ovf. Set has priority when both occur at the same edge.
- FSM: EMPTY (out_valid=0), STREAM (out_valid=1, pending=0), STREAM_PEND (out_valid=1, pending=1).
  - EMPTY→STREAM on commit.
  - STREAM→STREAM_PEND on a commit while not free.
  - STREAM_PEND→STREAM on the last byte with no commit.
  - STREAM→EMPTY on the last byte with no commit.
  - STREAM_PEND stays on a commit while not free (overflow).

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, overflow=0, pending=0, idx=0. S, P and O are cleared to 0.
- rst mid-stream aborts immediately: no further bytes, pending is dropped.
- Latency: out_valid=1 in the cycle after the commit edge (mmu_cycle==4 sampled). First byte = c00 first byte.
- With out_ready held high, one byte per cycle. Eight bytes take exactly one 8-cycle MMU period.
  - The last-byte accept coincides with the next commit edge, so streaming is continuous with no bubble and pending is never used.
- out_data and out_valid are registered or decoded from registers only. There is no combinational path from out_ready.
- Stalling: while out_ready=0, out_data and idx hold.

## Test plan
- Single matmul, LSB_FIRST=0, out_ready=1. Inputs: c00=0x1234 at cycle 2, c01=0xABCD and c10=0x0001 at cycle 3, c11=0xFFFE at cycle 4 → bytes 12 34 AB CD 00 01 FF FE on 8 consecutive cycles starting the cycle after the cycle-4 edge; then out_valid=0.
- Back-to-back sets with out_ready=1 over 3 MMU periods → 24 contiguous valid bytes, pending never 1, overflow=0.
- out_ready=0 for 10 cycles after the first byte while the second set commits → pending=1, busy=1. On release, set 2 follows set 1 with no bubble; overflow=0.
- out_ready=0 across two further commits → overflow=1 and stays sticky. The stream then delivers set 1 followed by set 3 (set 2 lost). clr_ovf → overflow=0.
- LSB_FIRST=1 with c00=0x1234 → first two bytes 34 12. mmu_en dropped at cycle 3 → no commit and out_valid stays 0.
- rst asserted mid-stream at idx=3 with pending=1 → next cycle out_valid=0, busy=0, out_data=0, pending=0.
